// File: rtl/uart_tx_arb.sv
// Round-robin arbiter in front of a single UART transmitter core: grants one requester,
// hands its byte over with a start pulse, waits for the frame (watchdogged), then idles a gap.
module uart_tx_arb #(
  parameter  int DATAWIDTH  = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int GAP_CYCLES = 16,
  parameter  int TIMEOUT    = 65535,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [DATAWIDTH-1:0]           tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [ID_W-1:0]                grant_id,
  output logic                           arb_busy,
  output logic                           timeout_err
);

  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  // With no gap configured a finished (or abandoned) frame returns straight to IDLE.
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [DATAWIDTH-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 tx_start_q, tx_start_d;
  logic                 timeout_q, timeout_d;
  logic [WD_W-1:0]      wd_q, wd_d, wd_inc;
  logic [GAP_W-1:0]     gap_q, gap_d, gap_inc;

  logic                 any_req;
  logic [ID_W-1:0]      win, idx;
  logic [DATAWIDTH-1:0] win_data;
  logic [NUM_REQ-1:0]   win_onehot;

  // Rotating search beginning just after the previous winner.
  always_comb begin
    any_req = 1'b0;
    win     = last_q;
    idx     = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == ID_W'(k)) begin
        win_data      = req_data[k*DATAWIDTH +: DATAWIDTH];
        win_onehot[k] = 1'b1;
      end
    end
  end

  // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    wd_d       = wd_q;
    gap_d      = gap_q;
    wd_inc     = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
    gap_inc    = (gap_q == GAP_W'(GAP_CYCLES)) ? gap_q : gap_q + GAP_W'(1);

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = START;
          last_d     = win;
          grant_id_d = win;
          tx_data_d  = win_data;
          grant_d    = win_onehot;
          tx_start_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
        wd_d    = '0;
      end
      WAIT_BUSY, WAIT_DONE: begin
        wd_d = wd_inc;
        // Completion beats an expiry landing on the same edge.
        if (tx_done) begin
          state_d = AFTER_FRAME;
        end else if (wd_inc == WD_W'(TIMEOUT)) begin
          state_d   = AFTER_FRAME;
          timeout_d = 1'b1;
        end else if (state_q == WAIT_BUSY && tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      GAP: begin
        gap_d = gap_inc;
        if (gap_inc == GAP_W'(GAP_CYCLES)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == GAP && state_q != GAP) gap_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
    end
  end

  assign grant       = grant_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_q;
  assign arb_busy    = (state_q != IDLE);

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8: width of one UART data byte.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 16: idle clocks inserted between frames (0 = none).
REQ-004 The block SHALL have parameter TIMEOUT, default 65535: maximum clocks to wait for tx_done after a start.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic rises on posedge clk.
REQ-006 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port req, input, NUM_REQ: per-requester send request, held high until granted.
REQ-008 The block SHALL have port req_data, input, NUM_REQ*DATAWIDTH: requester i's byte in bits [i*DATAWIDTH +: DATAWIDTH].
REQ-009 The block SHALL have port grant, output, NUM_REQ: one-hot, one-cycle pulse that acknowledges the requester whose byte was taken.
REQ-010 The block SHALL have port tx_data, output, DATAWIDTH: registered byte to the transmitter core.
REQ-011 The block SHALL have port tx_start, output, 1: one-cycle start pulse to the transmitter core.
REQ-012 The block SHALL have port tx_busy, input, 1: transmitter frame in progress.
REQ-013 The block SHALL have port tx_done, input, 1: one-cycle pulse when the stop bit completes.
REQ-014 The block SHALL have port grant_id, output, clog2(NUM_REQ) (minimum 1): index of the last granted requester.
REQ-015 The block SHALL have port arb_busy, output, 1: high whenever the state is not IDLE.
REQ-016 The block SHALL have port timeout_err, output, 1: one-cycle pulse on watchdog expiry.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE and GAP.
REQ-018 IDLE: on a clock edge with any req bit high, the FSM SHALL go to START, register tx_data and grant_id from the winner, and raise grant[winner] and tx_start for exactly the START cycle.
REQ-019 Latency: if req is sampled high in IDLE at edge N, grant and tx_start SHALL be high during cycle N+1.
REQ-020 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod NUM_REQ and takes the first req bit set.
REQ-021 last_winner SHALL reset to NUM_REQ-1, so that requester 0 has priority first.
REQ-022 START SHALL go to WAIT_BUSY unconditionally after one cycle.
REQ-023 WAIT_BUSY: tx_busy high SHALL lead to WAIT_DONE, and tx_done high SHALL lead directly to GAP, or to IDLE if GAP_CYCLES = 0.
REQ-024 WAIT_DONE: tx_done high SHALL lead to GAP, or to IDLE if GAP_CYCLES = 0; tx_busy falling without tx_done SHALL be ignored.
REQ-025 GAP SHALL count GAP_CYCLES clocks, then go to IDLE; the gap counter SHALL clear on GAP entry.
REQ-026 The watchdog SHALL clear in START and count every cycle in WAIT_BUSY/WAIT_DONE.
REQ-027 When the watchdog reaches TIMEOUT, timeout_err SHALL pulse for one cycle and the FSM SHALL go to GAP (IDLE if GAP_CYCLES = 0).
REQ-028 If tx_done arrives in the same cycle the watchdog reaches TIMEOUT, tx_done SHALL win: no timeout_err.
REQ-029 req changes outside IDLE SHALL be ignored, and no grant SHALL issue outside START.
REQ-030 A requester dropping req before it is granted SHALL lose its turn without error.
REQ-031 tx_data SHALL hold its value from START until the next START.
REQ-032 grant SHALL be one-hot or zero at all times, and tx_start and grant SHALL never assert in consecutive cycles.
REQ-033 Counter widths SHALL be clog2(max value)+1 bits, and neither counter SHALL wrap: each saturates at its terminal count.

Reset
REQ-034 While rst is high at a clock edge, the FSM SHALL go to IDLE, clear both counters and set last_winner to NUM_REQ-1.
REQ-035 Under that reset, grant, tx_start, timeout_err and arb_busy SHALL be 0, and tx_data and grant_id SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame immediately with no grant, tx_start or timeout_err pulse; the transmitter core is reset separately.
REQ-037 The first arbitration after reset release SHALL use the reset value of last_winner.

Verification
REQ-038 The bench SHALL cover a single request: req=4'b0100, req_data[2]=8'hA5 -> grant=4'b0100 and tx_start=1 one cycle after, tx_data=8'hA5, grant_id=2.
REQ-039 The bench SHALL cover round-robin: req=4'b1111 held, model tx_done each frame -> grants in order 0,1,2,3,0, each separated by frame plus GAP_CYCLES clocks.
REQ-040 The bench SHALL cover the timeout: TIMEOUT=100, tx_busy and tx_done never asserted -> timeout_err pulse exactly 100 cycles after the WAIT_BUSY entry, then IDLE after the gap.
REQ-041 The bench SHALL cover reset mid-frame: rst pulsed in WAIT_DONE -> arb_busy=0 next cycle and the next grant goes to requester 0.
REQ-042 The bench SHALL cover GAP_CYCLES=0 with tx_done in WAIT_BUSY -> IDLE the next cycle and back-to-back grants with exactly 3-cycle spacing.
REQ-043 The bench SHALL cover a simultaneous tx_done and watchdog expiry -> no timeout_err, normal return to GAP.
